// File: rtl/h14tx_pll_seq.sv
// HDMI TX PLL divider/reset sequencer with lock supervision.
// Optional lock-loss/retry counters: H14TX_PLL_SEQ_LOSS_CNT_EN.
module h14tx_pll_seq #(
  parameter logic [5:0] DefIdsel      = 6'd0,
  parameter logic [6:0] DefMdsel      = 7'd0,
  parameter logic [6:0] DefOdsel      = 7'd0,
  parameter int         QuiesceCycles = 16,
  parameter int         ResetHold     = 32,
  parameter int         LockTimeout   = 65535,
  parameter int         StableCycles  = 1024,
  parameter int         MaxRetries    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [5:0] req_idsel,
  input  logic [6:0] req_mdsel,
  input  logic [6:0] req_odsel,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [6:0] pll_mdsel,
  output logic [6:0] pll_odsel,
  output logic       tmds_en,
  output logic       busy,
  output logic       fail
`ifdef H14TX_PLL_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0] loss_cnt,
  output logic [1:0] retry_cnt
`endif
);

  localparam int M1 = (QuiesceCycles > ResetHold) ? QuiesceCycles : ResetHold;
  localparam int M2 = (LockTimeout > StableCycles) ? LockTimeout : StableCycles;
  localparam int MaxCnt = (M1 > M2) ? M1 : M2;
  localparam int CW = $clog2(MaxCnt + 1);
  localparam int RW = (MaxRetries < 2) ? 1 : $clog2(MaxRetries + 1);

  localparam logic [CW-1:0] QEnd = CW'(QuiesceCycles - 1);
  localparam logic [CW-1:0] REnd = CW'(ResetHold - 1);
  localparam logic [CW-1:0] TEnd = CW'(LockTimeout);
  localparam logic [CW-1:0] SEnd = CW'(StableCycles);
  localparam logic [CW-1:0] CMax = '1;
  localparam logic [RW-1:0] RMax = RW'(MaxRetries);

  typedef enum logic [2:0] {
    ST_RUN,
    ST_QUIESCE,
    ST_RESET,
    ST_WAIT,
    ST_STABLE,
    ST_FAIL
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [RW-1:0] retry_q, retry_d;
  logic          lock_m, lock_s;
  logic          hs, pend_ld;
  logic [5:0]    pend_idsel;
  logic [6:0]    pend_mdsel;
  logic [6:0]    pend_odsel;

  assign hs = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    pend_ld = 1'b0;
    cnt_inc = (cnt_q == CMax) ? cnt_q : cnt_q + 1'b1;
    unique case (state_q)
      ST_RUN: begin
        if (hs) begin
          state_d = ST_QUIESCE;
          cnt_d   = '0;
          retry_d = '0;
          pend_ld = 1'b1;
        end else if (!lock_s) begin
          state_d = ST_QUIESCE;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      ST_QUIESCE: begin
        if (cnt_q == QEnd) begin
          state_d = ST_RESET;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RESET: begin
        if (cnt_q == REnd) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WAIT: begin
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_inc == TEnd) begin
          cnt_d = '0;
          if (retry_q < RMax) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_RESET;
          end else begin
            state_d = ST_FAIL;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          cnt_d = '0;
          if (retry_q < RMax) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_RESET;
          end else begin
            state_d = ST_FAIL;
          end
        end else if (cnt_q == SEnd) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_FAIL: begin
        if (hs) begin
          state_d = ST_QUIESCE;
          cnt_d   = '0;
          retry_d = '0;
          pend_ld = 1'b1;
        end
      end
      default: begin
        state_d = ST_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RESET;
      cnt_q      <= '0;
      retry_q    <= '0;
      pend_idsel <= DefIdsel;
      pend_mdsel <= DefMdsel;
      pend_odsel <= DefOdsel;
      pll_idsel  <= DefIdsel;
      pll_mdsel  <= DefMdsel;
      pll_odsel  <= DefOdsel;
      pll_reset  <= 1'b1;
      tmds_en    <= 1'b0;
      busy       <= 1'b1;
      fail       <= 1'b0;
      req_ready  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      if (pend_ld) begin
        pend_idsel <= req_idsel;
        pend_mdsel <= req_mdsel;
        pend_odsel <= req_odsel;
      end
      if (state_d == ST_RESET && state_q != ST_RESET) begin
        pll_idsel <= pend_idsel;
        pll_mdsel <= pend_mdsel;
        pll_odsel <= pend_odsel;
      end
      pll_reset <= (state_d == ST_RESET) || (state_d == ST_FAIL);
      tmds_en   <= (state_d == ST_RUN);
      busy      <= !((state_d == ST_RUN) || (state_d == ST_FAIL));
      fail      <= (state_d == ST_FAIL);
      req_ready <= (state_d == ST_RUN) || (state_d == ST_FAIL);
    end
  end

`ifdef H14TX_PLL_SEQ_LOSS_CNT_EN
  logic loss_ev;
  assign loss_ev = (state_q == ST_RUN) && !hs && !lock_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_cnt <= 8'd0;
    end else if (loss_ev && loss_cnt != 8'hff) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end

  assign retry_cnt = 2'(retry_q);
`endif

endmodule

// File: doc/h14tx_pll_seq.md
Name: h14tx_pll_seq

Overview:
Sequencer for the HDMI TX serial-clock PLL's dynamic divider inputs and reset.
- Accepts divider-change requests (IDSEL/MDSEL/ODSEL0 codes) over a valid/ready handshake.
- Runs the full change sequence: quiesce the TMDS path, hold the PLL in reset, wait for lock with timeout and retry, then re-enable TMDS.
- Runs on the free-running 50 MHz reference clock, beside the PLL/CLKDIV clock block.
- Also supervises lock loss during normal operation.

Parameters:
- DefIdsel, 6'd0: IDSEL code applied after reset.
- DefMdsel, 7'd0: MDSEL code applied after reset.
- DefOdsel, 7'd0: ODSEL0 code applied after reset.
- QuiesceCycles, 16: clk cycles with tmds_en low before the PLL is reset.
- ResetHold, 32: clk cycles pll_reset is held high.
- LockTimeout, 65535: clk cycles to wait for lock before a retry.
- StableCycles, 1024: consecutive synchronized lock-high cycles required.
- MaxRetries, 3: retries before entering FAIL.

Ports:
- clk, input, 1: reference clock, sole clock domain.
- rst, input, 1: asynchronous, active-high reset.
- req_valid, input, 1: divider-change request.
- req_ready, output, 1: request accepted when req_valid && req_ready.
- req_idsel, input, 6: requested IDSEL code.
- req_mdsel, input, 7: requested MDSEL code.
- req_odsel, input, 7: requested ODSEL0 code.
- pll_lock, input, 1: raw PLL LOCK, asynchronous to clk.
- pll_reset, output, 1: to PLL RESET.
- pll_idsel, output, 6: to PLL IDSEL.
- pll_mdsel, output, 7: to PLL MDSEL.
- pll_odsel, output, 7: to PLL ODSEL0.
- tmds_en, output, 1: enable for the TMDS reset synchronizer/serializers.
- busy, output, 1: sequence in progress.
- fail, output, 1: retries exhausted, sticky until a new request or rst.

Behaviour:
Reset values:
- pll_reset=1, tmds_en=0, busy=1, fail=0, req_ready=0.
- pll_idsel/mdsel/odsel = DefIdsel/DefMdsel/DefOdsel.
- State=RESET, counters=0.

Lock synchronization and outputs:
- pll_lock passes through a 2-flop synchronizer (lock_s). All decisions use lock_s.
- All outputs are registered.

States:
- RUN:
  - tmds_en=1, busy=0, req_ready=1.
  - On handshake: latch the req_* codes into a pending register, then go to QUIESCE.
  - If lock_s falls (and there is no handshake that cycle): go to QUIESCE, retry count cleared.
  - Handshake and lock loss in the same cycle: the handshake wins; the new codes are used.
- QUIESCE:
  - tmds_en=0. Count QuiesceCycles, then go to RESET.
- RESET:
  - pll_reset=1.
  - On the first cycle of RESET, pll_*sel take the pending codes. They then stay constant while pll_reset is high.
  - After ResetHold cycles: pll_reset=0, go to WAIT_LOCK.
- WAIT_LOCK:
  - Timeout counter increments each cycle.
  - lock_s=1: go to STABLE.
  - Counter reaches LockTimeout:
    - If retry < MaxRetries: retry++, go to RESET.
    - Else: go to FAIL.
- STABLE:
  - Counts consecutive lock_s=1 cycles.
  - lock_s=0 before StableCycles: retry++, go to RESET. If retries are already exhausted, go to FAIL instead.
  - StableCycles reached: go to RUN, retry cleared, tmds_en=1 on the next cycle.
- FAIL:
  - fail=1, pll_reset=1, tmds_en=0, busy=0, req_ready=1.
  - A handshake clears fail and starts QUIESCE with the new codes.

Request handling outside RUN/FAIL:
- req_ready=0 in all other states; requests wait (valid must be held by the sender).

Latency:
- From handshake to tmds_en rise: QuiesceCycles + ResetHold + (lock wait) + StableCycles + 2 pipeline cycles.

Counters:
- Widths are derived with $clog2 of the largest parameter.
- The timeout counter saturates and never wraps.

Reset mid-operation:
- An asynchronous rst at any state returns immediately to the reset values and restarts from DEF* codes.
- Nothing survives reset; the pending request is lost.

Optional Feature:
Macro H14TX_PLL_SEQ_LOSS_CNT_EN.
- Defined:
  - Adds output loss_cnt[7:0]: a saturating count (stops at 255) of lock-loss events detected in RUN.
  - Adds output retry_cnt[1:0] = current retry count.
  - Both reset to 0. loss_cnt is not cleared by requests.
- Undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Test Plan:
1. Reset release, pll_lock high 100 cycles after pll_reset falls -> pll_reset low after 32 cycles; tmds_en=1 exactly StableCycles+2 cycles after lock_s rises; busy=0; codes = DEF*.
2. In RUN, request idsel=2, mdsel=53, odsel=5 -> tmds_en low next cycle; pll_reset high after 16 cycles; pll_*sel=2/53/5 while reset; req_ready=0 until RUN returns.
3. pll_lock held low -> three retries, each 32+65535 cycles; then fail=1, pll_reset=1; a subsequent request clears fail.
4. pll_lock glitches low for 1 cycle at STABLE count 500 -> retry++, return to RESET; next clean lock reaches RUN with retry cleared.
5. In RUN, drop pll_lock -> QUIESCE and relock sequence; with macro defined, loss_cnt increments 0->1; 300 losses -> loss_cnt=255.
6. Assert rst during WAIT_LOCK after a request -> outputs return to reset values immediately; codes revert to DEF*.
